// File: rtl/_rr_mux_if.sv
// Handshake bundle between N producers, the arbitrated mux and one consumer.
// slave is the mux's view; master is the environment's view.
interface _rr_mux_if #(
    parameter int n        = 8,
    parameter int CHANNELS = 32
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*n-1:0] in_data;
    logic [CHANNELS-1:0]   in_valid;
    logic [CHANNELS-1:0]   in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [n-1:0]          out_data;
    logic [SEL_W-1:0]      out_src;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/_rr_mux.sv
// N-channel arbitrated multiplexer: round-robin or forced selection feeding
// a single registered output stage with valid/ready back-pressure.
module _rr_mux #(
    parameter int n        = 8,
    parameter int CHANNELS = 32,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic      clk,
    input  logic      rst_n,
    _rr_mux_if.slave  bus
);

    logic [SEL_W-1:0] ptr;
    logic             can_load;
    logic             grant_any;
    logic [SEL_W-1:0] grant_idx;
    logic             hi_any;
    logic [SEL_W-1:0] hi_idx;
    logic             lo_any;
    logic [SEL_W-1:0] lo_idx;
    logic [n-1:0]     grant_data;
    logic             transfer;

    // Round-robin: lowest requester above the pointer, else lowest requester
    // overall (the wrap). The downward scan leaves the lowest match last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned (that would infer a latch).
        hi_any    = 1'b0;
        hi_idx    = '0;
        lo_any    = 1'b0;
        lo_idx    = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                lo_any = 1'b1;
                lo_idx = SEL_W'(i);
                if (SEL_W'(i) > ptr) begin
                    hi_any = 1'b1;
                    hi_idx = SEL_W'(i);
                end
            end
        end
        if (bus.mode) begin
            // Comparing against each real index keeps out-of-range sel values
            // from ever producing a grant.
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else if (hi_any) begin
            grant_any = 1'b1;
            grant_idx = hi_idx;
        end else begin
            grant_any = lo_any;
            grant_idx = lo_idx;
        end
    end

    always_comb begin
        can_load   = !bus.out_valid || bus.out_ready;
        transfer   = grant_any && can_load;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.in_ready[i] = transfer && (grant_idx == SEL_W'(i));
            if (grant_idx == SEL_W'(i)) grant_data = bus.in_data[i*n +: n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: registered state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            ptr           <= SEL_W'(CHANNELS - 1);
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
        end else if (transfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= grant_data;
            bus.out_src   <= grant_idx;
            if (!bus.mode) ptr <= grant_idx;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb__rr_mux.sv
// Self-checking bench for _rr_mux (5 channels, 8-bit words): directed scenarios
// with literal expectations, then random traffic against a behavioural model.
module tb__rr_mux;
    localparam int C = 5;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   run    = 1'b0;

    always #5 clk = ~clk;

    _rr_mux_if #(.n(W), .CHANNELS(C)) bus ();

    _rr_mux #(.n(W), .CHANNELS(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the pointer is the last round-robin winner; the grant
    // is the first requester found walking upward from it, modulo C.
    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_src;

    function automatic int model_grant();
        if (bus.mode) begin
            if (int'(bus.sel) < C) begin
                if (bus.in_valid[bus.sel]) return int'(bus.sel);
            end
            return -1;
        end
        for (int k = 1; k <= C; k++) begin
            if (bus.in_valid[(m_ptr + k) % C]) return (m_ptr + k) % C;
        end
        return -1;
    endfunction

    function automatic logic [C-1:0] model_ready();
        int g;
        g = model_grant();
        if (g >= 0 && (!m_valid || bus.out_ready)) return C'(1 << g);
        return '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   <= C - 1;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
        end else if (model_grant() >= 0 && (!m_valid || bus.out_ready)) begin
            m_valid <= 1'b1;
            m_data  <= bus.in_data[model_grant()*W +: W];
            m_src   <= model_grant();
            if (!bus.mode) m_ptr <= model_grant();
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("in_ready", 64'(bus.in_ready), 64'(model_ready()));
            check("out_valid", 64'(bus.out_valid), 64'(m_valid));
            check("out_data", 64'(bus.out_data), 64'(m_data));
            check("out_src", 64'(bus.out_src), 64'(m_src));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic all_channels();
        for (int i = 0; i < C; i++) bus.in_data[i*W +: W] = 8'h10 + 8'(i);
        bus.in_valid = '1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        #1 run = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // Asynchronous reset while a word is held
        bus.in_valid = 5'b00100;
        bus.in_data[2*W +: W] = 8'h11;
        step();
        check("preload_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_data", 64'(bus.out_data), 64'd0);
        check("async_rst_src", 64'(bus.out_src), 64'd0);

        // Fairness from reset: 0,1,2,3,4,0
        all_channels();
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1 check("first_cycle_valid", 64'(bus.out_valid), 64'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_src", 64'(bus.out_src), 64'(k % C));
            check("rr_data", 64'(bus.out_data), 64'(8'h10 + 8'(k % C)));
        end

        // Single requester is granted every cycle
        bus.in_data  = '0;
        bus.in_data[2*W +: W] = 8'hA5;
        bus.in_valid = 5'b00100;
        for (int k = 0; k < 4; k++) begin
            #1 check("single_ready", 64'(bus.in_ready), 64'b00100);
            step();
            check("single_data", 64'(bus.out_data), 64'hA5);
            check("single_src", 64'(bus.out_src), 64'd2);
        end

        // Back-pressure holds the word and blocks all inputs
        bus.in_valid = 5'b00010;
        bus.in_data[1*W +: W] = 8'h3C;
        step();
        check("bp_load", 64'(bus.out_data), 64'h3C);
        bus.in_valid  = 5'b01000;
        bus.in_data[3*W +: W] = 8'h77;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_ready", 64'(bus.in_ready), 64'd0);
            step();
            check("bp_hold_data", 64'(bus.out_data), 64'h3C);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", 64'(bus.in_ready), 64'b01000);
        step();
        check("bp_reload_valid", 64'(bus.out_valid), 64'd1);
        check("bp_reload_data", 64'(bus.out_data), 64'h77);
        check("bp_reload_src", 64'(bus.out_src), 64'd3);

        // Forced mode leaves the pointer at its reset value
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        bus.mode = 1'b1;
        bus.sel  = 3'd3;
        all_channels();
        #1 check("forced_ready", 64'(bus.in_ready), 64'b01000);
        for (int k = 0; k < 4; k++) begin
            step();
            check("forced_src", 64'(bus.out_src), 64'd3);
        end
        bus.mode = 1'b0;
        #1 check("after_forced_ready", 64'(bus.in_ready), 64'b00001);
        step();
        check("after_forced_src", 64'(bus.out_src), 64'd0);

        // Out-of-range select never grants
        bus.mode = 1'b1;
        bus.sel  = 3'd6;
        #1 check("oor_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("oor_drain", 64'(bus.out_valid), 64'd0);
        step();
        check("oor_idle", 64'(bus.out_valid), 64'd0);

        // Reset during a stall discards the held word
        bus.mode     = 1'b0;
        bus.in_valid = 5'b00100;
        bus.in_data[2*W +: W] = 8'h5A;
        step();
        bus.out_ready = 1'b0;
        step();
        check("stall_data", 64'(bus.out_data), 64'h5A);
        #1 rst_n = 1'b0;
        #1 check("stall_rst_valid", 64'(bus.out_valid), 64'd0);
        bus.in_valid  = 5'b10001;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        #1 check("stall_rst_ready", 64'(bus.in_ready), 64'b00001);
        step();
        check("stall_rst_src", 64'(bus.out_src), 64'd0);

        // Random traffic, model-checked every cycle
        repeat (3000) begin
            bus.in_valid  = C'($urandom());
            bus.in_data   = (C*W)'({$urandom(), $urandom()});
            bus.mode      = ($urandom_range(0, 3) == 0);
            bus.sel       = 3'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
